img_rsz_collector: RTL and testbench
====================================

# img_rsz_collector

Receiving end of the resized-pixel valid/ready interface driven by the resized-pixel forwarder. Accepts resized pixels tagged with tile-local (X, Y) indices in arbitrary arrival order (serial forwarding emits them in find-first-set order, not raster order). Buffers one tile of RSZ_IMG_WIDTH_SIZE x RSZ_IMG_HEIGHT_SIZE pixels and re-emits them as a strictly raster-ordered stream with first/last tile markers for the downstream frame writer.

## Interface
Parameters:
- RSZ_W, default RSZ_IMG_WIDTH_SIZE: tile width in resized pixels.
- RSZ_H, default RSZ_IMG_HEIGHT_SIZE: tile height in resized pixels.
- X_IDX_W, default RSZ_IMG_WIDTH_IDX_W: width of the X index, at least clog2(RSZ_W), minimum 1.
- Y_IDX_W, default RSZ_IMG_HEIGHT_IDX_W: width of the Y index, at least clog2(RSZ_H), minimum 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RszPxlData  in  FcRszPxlData_t  resized pixel, all primary colours.
- RszPxlX  in  X_IDX_W  tile column of the incoming pixel.
- RszPxlY  in  Y_IDX_W  tile row of the incoming pixel.
- RszPxlVld  in  1  incoming pixel valid.
- RszPxlRdy  out  1  collector can store the pixel at (RszPxlX, RszPxlY).
- OutPxlData  out  FcRszPxlData_t  raster-ordered pixel.
- OutPxlX  out  X_IDX_W  column of OutPxlData.
- OutPxlY  out  Y_IDX_W  row of OutPxlData.
- OutPxlFirst  out  1  OutPxlData is at (0,0).
- OutPxlLast  out  1  OutPxlData is at (RSZ_W-1, RSZ_H-1).
- OutPxlVld  out  1  output pixel valid.
- OutPxlRdy  in  1  downstream accepts the output pixel.
- TileCnt  out  16  number of completed tiles, wraps modulo 2^16.
- ErrOor  out  1  sticky out-of-range index flag (see Configuration).

## Operation
- State: pixel array Buf[RSZ_H][RSZ_W] and occupancy flags Full[RSZ_H][RSZ_W]; raster pointer (RX, RY); TileCnt.
- Write: RszPxlRdy = ~Full[RszPxlY][RszPxlX]. On RszPxlVld & RszPxlRdy, store the pixel in Buf and set Full. A duplicate index to an occupied slot stalls until that slot drains.
- Read: OutPxlVld = Full[RY][RX]. OutPxlData = Buf[RY][RX]. OutPxlX = RX. OutPxlY = RY. OutPxlFirst = (RX==0 && RY==0). OutPxlLast = (RX==RSZ_W-1 && RY==RSZ_H-1).
- On OutPxlVld & OutPxlRdy: clear Full[RY][RX], then advance the pointer.
  - RX increments.
  - At RSZ_W-1, RX wraps to 0 and RY increments.
  - At the last pixel, RY wraps to 0 and TileCnt increments.
- Slots already drained for the current tile may accept pixels of the next tile immediately; no tile-boundary bubble.
- Simultaneous write and drain of the same slot cannot occur, because Rdy is low while the slot is Full. The slot becomes writable in the cycle after the drain.
- Simultaneous write to another slot and drain are independent, with no priority conflict.
- Output signals remain stable while OutPxlVld=1 and OutPxlRdy=0.

## Timing
- Reset values: all Full=0, RX=RY=0, TileCnt=0, ErrOor=0. Consequently RszPxlRdy=1, OutPxlVld=0, OutPxlFirst=1, OutPxlLast=0. Buf is not reset.
- Latency: a pixel written at edge N appears on the output in cycle N+1, provided it is at the raster pointer.
- Throughput: 1 pixel/cycle in and 1 pixel/cycle out when arrival is in raster order.
- Reset assertion mid-tile discards all buffered pixels and returns the pointer to (0,0) asynchronously.

## Configuration
- IMG_RSZ_COLLECTOR_OOR_CHK_EN defined:
  - An input with RszPxlX >= RSZ_W or RszPxlY >= RSZ_H is accepted with RszPxlRdy=1 and dropped; no state changes.
  - ErrOor is set and held until reset.
- Undefined: ErrOor is tied to 0 and no range logic is built. Out-of-range indices are a protocol violation with unspecified result.

## Structure
- Types and constants in ImgRszPkg: FcRszPxlData_t, PXL_PRIM_COLOR_NUM, RSZ_IMG_WIDTH_SIZE, RSZ_IMG_HEIGHT_SIZE, RSZ_IMG_WIDTH_IDX_W, RSZ_IMG_HEIGHT_IDX_W.
- Sub-module img_rsz_raster_cnt: X/Y wrap counter with an enable, first/last flags, and a tile-done pulse that drives TileCnt.

## Test plan
- Raster-order input on a 4x2 tile with OutPxlRdy=1: pixels 0..7 out in the cycle after each write; First on (0,0); Last on (3,1); TileCnt=1.
- Reverse-order input (3,1) down to (0,0): OutPxlVld stays 0 until (0,0) is written, then 8 consecutive beats in raster order.
- Duplicate (1,0) sent while (1,0) is Full and OutPxlRdy=0: RszPxlRdy=0 until the pointer drains (1,0); the second value is accepted the cycle after and emitted in the next tile.
- Back-to-back tiles with random OutPxlRdy backpressure: 3 tiles lossless and in order; TileCnt=3; output stable during stalls.
- rst_n pulsed low after 5 of 8 pixels are written: Full cleared, OutPxlVld=0, RX=RY=0, TileCnt=0. A fresh tile completes normally.
- With IMG_RSZ_COLLECTOR_OOR_CHK_EN, send X=5 on a width-4 tile: accepted and dropped, ErrOor=1 persists, and a following valid tile is unaffected.

Source files
------------

// File: rtl/img_rsz_collector_pkg.sv
// ============================================================================
// Package     : ImgRszPkg
// Description : Shared types and tile geometry for the resized-pixel path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ImgRszPkg;

    localparam int PXL_PRIM_COLOR_NUM   = 3;
    localparam int PXL_COLOR_W          = 8;
    localparam int RSZ_IMG_WIDTH_SIZE   = 4;
    localparam int RSZ_IMG_HEIGHT_SIZE  = 2;

    // Index width for a count of n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RSZ_IMG_WIDTH_IDX_W  = idx_width(RSZ_IMG_WIDTH_SIZE);
    localparam int RSZ_IMG_HEIGHT_IDX_W = idx_width(RSZ_IMG_HEIGHT_SIZE);

    typedef logic [PXL_PRIM_COLOR_NUM-1:0][PXL_COLOR_W-1:0] FcRszPxlData_t;

endpackage

`default_nettype wire

// File: rtl/img_rsz_collector_raster_cnt.sv
// ============================================================================
// Module      : img_rsz_raster_cnt
// Description : X/Y raster wrap counter with first/last flags and tile-done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module img_rsz_raster_cnt #(
    parameter int W       = 4,
    parameter int H       = 2,
    parameter int X_IDX_W = 2,
    parameter int Y_IDX_W = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [X_IDX_W-1:0] x,
    output logic [Y_IDX_W-1:0] y,
    output logic               first,
    output logic               last,
    output logic               tile_done
);

    logic w_x_at_end;
    logic w_y_at_end;

    assign w_x_at_end = (x == X_IDX_W'(W - 1));
    assign w_y_at_end = (y == Y_IDX_W'(H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (w_x_at_end) begin
                x <= '0;
                y <= w_y_at_end ? '0 : y + Y_IDX_W'(1);
            end else begin
                x <= x + X_IDX_W'(1);
            end
        end
    end

    assign first     = (x == '0) && (y == '0);
    assign last      = w_x_at_end && w_y_at_end;
    assign tile_done = en && last;

endmodule

`default_nettype wire

// File: rtl/img_rsz_collector.sv
// ============================================================================
// Module      : img_rsz_collector
// Description : Buffers one tile of out-of-order resized pixels and re-emits
//               them in raster order. Optional IMG_RSZ_COLLECTOR_OOR_CHK_EN
//               drops out-of-range indices and raises sticky ErrOor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module img_rsz_collector
    import ImgRszPkg::*;
#(
    parameter int RSZ_W   = RSZ_IMG_WIDTH_SIZE,
    parameter int RSZ_H   = RSZ_IMG_HEIGHT_SIZE,
    parameter int X_IDX_W = RSZ_IMG_WIDTH_IDX_W,
    parameter int Y_IDX_W = RSZ_IMG_HEIGHT_IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  FcRszPxlData_t      RszPxlData,
    input  logic [X_IDX_W-1:0] RszPxlX,
    input  logic [Y_IDX_W-1:0] RszPxlY,
    input  logic               RszPxlVld,
    output logic               RszPxlRdy,
    output FcRszPxlData_t      OutPxlData,
    output logic [X_IDX_W-1:0] OutPxlX,
    output logic [Y_IDX_W-1:0] OutPxlY,
    output logic               OutPxlFirst,
    output logic               OutPxlLast,
    output logic               OutPxlVld,
    input  logic               OutPxlRdy,
    output logic [15:0]        TileCnt,
    output logic               ErrOor
);

    localparam int C_PXL_NUM   = RSZ_W * RSZ_H;
    localparam int C_PXL_IDX_W = idx_width(C_PXL_NUM);

    logic [C_PXL_NUM-1:0]   r_full;
    FcRszPxlData_t          r_buf [C_PXL_NUM];
    logic [15:0]            r_tile_cnt;

    logic [C_PXL_IDX_W-1:0] w_wr_idx;
    logic [C_PXL_IDX_W-1:0] w_rd_idx;
    logic [X_IDX_W-1:0]     w_rx;
    logic [Y_IDX_W-1:0]     w_ry;
    logic                   w_slot_free;
    logic                   w_wr_fire;
    logic                   w_rd_fire;
    logic                   w_tile_done;

    // Both indices flatten (x, y) row-major into the single buffer array.
    assign w_wr_idx    = C_PXL_IDX_W'(32'(RszPxlY) * 32'(RSZ_W) + 32'(RszPxlX));
    assign w_rd_idx    = C_PXL_IDX_W'(32'(w_ry) * 32'(RSZ_W) + 32'(w_rx));
    assign w_slot_free = ~r_full[w_wr_idx];

`ifdef IMG_RSZ_COLLECTOR_OOR_CHK_EN
    logic w_in_range;
    logic r_err_oor;

    assign w_in_range = (32'(RszPxlX) < 32'(RSZ_W)) && (32'(RszPxlY) < 32'(RSZ_H));
    assign RszPxlRdy  = ~w_in_range | w_slot_free;
    assign w_wr_fire  = RszPxlVld & w_in_range & w_slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_oor <= 1'b0;
        end else if (RszPxlVld && !w_in_range) begin
            r_err_oor <= 1'b1;
        end
    end

    assign ErrOor = r_err_oor;
`else
    assign RszPxlRdy = w_slot_free;
    assign w_wr_fire = RszPxlVld & w_slot_free;
    assign ErrOor    = 1'b0;
`endif

    assign OutPxlVld  = r_full[w_rd_idx];
    assign OutPxlData = r_buf[w_rd_idx];
    assign OutPxlX    = w_rx;
    assign OutPxlY    = w_ry;
    assign w_rd_fire  = OutPxlVld & OutPxlRdy;

    // Write needs an empty slot and drain needs a full one, so the two
    // updates below never target the same bit in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= '0;
        end else begin
            if (w_wr_fire) begin
                r_full[w_wr_idx] <= 1'b1;
            end
            if (w_rd_fire) begin
                r_full[w_rd_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_buf[w_wr_idx] <= RszPxlData;
        end
    end

    img_rsz_raster_cnt #(
        .W       (RSZ_W),
        .H       (RSZ_H),
        .X_IDX_W (X_IDX_W),
        .Y_IDX_W (Y_IDX_W)
    ) u_raster_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (w_rd_fire),
        .x         (w_rx),
        .y         (w_ry),
        .first     (OutPxlFirst),
        .last      (OutPxlLast),
        .tile_done (w_tile_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tile_cnt <= '0;
        end else if (w_tile_done) begin
            r_tile_cnt <= r_tile_cnt + 16'd1;
        end
    end

    assign TileCnt = r_tile_cnt;

endmodule

`default_nettype wire

// File: tb/tb_img_rsz_collector.sv
// ============================================================================
// Module      : tb_img_rsz_collector
// Description : Directed self-checking bench for img_rsz_collector (4x2 tile).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_img_rsz_collector;
    import ImgRszPkg::*;

    localparam int W  = RSZ_IMG_WIDTH_SIZE;
    localparam int H  = RSZ_IMG_HEIGHT_SIZE;
`ifdef IMG_RSZ_COLLECTOR_OOR_CHK_EN
    localparam int XW = RSZ_IMG_WIDTH_IDX_W + 1;
`else
    localparam int XW = RSZ_IMG_WIDTH_IDX_W;
`endif
    localparam int YW = RSZ_IMG_HEIGHT_IDX_W;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        FcRszPxlData_t d;
        logic          first;
        logic          last;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst_n;
    FcRszPxlData_t RszPxlData;
    logic [XW-1:0] RszPxlX;
    logic [YW-1:0] RszPxlY;
    logic          RszPxlVld;
    logic          RszPxlRdy;
    FcRszPxlData_t OutPxlData;
    logic [XW-1:0] OutPxlX;
    logic [YW-1:0] OutPxlY;
    logic          OutPxlFirst;
    logic          OutPxlLast;
    logic          OutPxlVld;
    logic          OutPxlRdy;
    logic [15:0]   TileCnt;
    logic          ErrOor;

    int checks   = 0;
    int failures = 0;

    img_rsz_collector #(
        .RSZ_W   (W),
        .RSZ_H   (H),
        .X_IDX_W (XW),
        .Y_IDX_W (YW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RszPxlData  (RszPxlData),
        .RszPxlX     (RszPxlX),
        .RszPxlY     (RszPxlY),
        .RszPxlVld   (RszPxlVld),
        .RszPxlRdy   (RszPxlRdy),
        .OutPxlData  (OutPxlData),
        .OutPxlX     (OutPxlX),
        .OutPxlY     (OutPxlY),
        .OutPxlFirst (OutPxlFirst),
        .OutPxlLast  (OutPxlLast),
        .OutPxlVld   (OutPxlVld),
        .OutPxlRdy   (OutPxlRdy),
        .TileCnt     (TileCnt),
        .ErrOor      (ErrOor)
    );

    always #5 clk = ~clk;

    function automatic FcRszPxlData_t pd(input int tag, input int x, input int y);
        return {8'(tag), 8'(y), 8'(x)};
    endfunction

    function automatic pix_t mk(input int tag, input int x, input int y);
        pix_t p;
        p.x     = XW'(x);
        p.y     = YW'(y);
        p.d     = pd(tag, x, y);
        p.first = (x == 0) && (y == 0);
        p.last  = (x == W - 1) && (y == H - 1);
        return p;
    endfunction

    function automatic pix_t observed();
        pix_t p;
        p.x     = OutPxlX;
        p.y     = OutPxlY;
        p.d     = OutPxlData;
        p.first = OutPxlFirst;
        p.last  = OutPxlLast;
        return p;
    endfunction

    // Entered and left at posedge+1; holds valid until the DUT is ready.
    task automatic send_pix(input pix_t p, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        RszPxlVld  = 1'b1;
        RszPxlX    = p.x;
        RszPxlY    = p.y;
        RszPxlData = p.d;
        while (n < 200) begin
            @(negedge clk);
            if (RszPxlRdy) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        RszPxlVld = 1'b0;
    endtask

    task automatic recv_pix(input int pct, output pix_t p, output bit ok, output bit stable);
        int   n;
        bit   have_prev;
        pix_t prev;
        n = 0; ok = 1'b0; stable = 1'b1; have_prev = 1'b0; prev = '0; p = '0;
        while (n < 200) begin
            OutPxlRdy = ($urandom_range(99) < pct);
            @(negedge clk);
            if (OutPxlVld) begin
                p = observed();
                if (have_prev && (p !== prev)) stable = 1'b0;
                if (OutPxlRdy) begin
                    ok = 1'b1;
                    @(posedge clk); #1;
                    break;
                end
                have_prev = 1'b1;
                prev      = p;
            end else if (have_prev) begin
                stable = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        OutPxlRdy = 1'b0;
    endtask

    task automatic stream(input pix_t sq[$], input int n_out, input int pct,
                          output pix_t got[$], output bit send_ok,
                          output bit recv_ok, output bit stable_ok);
        bit   ok_s, ok_r, st;
        pix_t p;
        got = {}; send_ok = 1'b1; recv_ok = 1'b1; stable_ok = 1'b1;
        fork
            begin
                foreach (sq[i]) begin
                    send_pix(sq[i], ok_s);
                    if (!ok_s) send_ok = 1'b0;
                end
            end
            begin
                for (int k = 0; k < n_out; k++) begin
                    recv_pix(pct, p, ok_r, st);
                    if (!ok_r) begin
                        recv_ok = 1'b0;
                        break;
                    end
                    if (!st) stable_ok = 1'b0;
                    got.push_back(p);
                end
            end
        join
    endtask

    task automatic test_reset();
        rst_n = 1'b0; RszPxlVld = 1'b0; RszPxlX = '0; RszPxlY = '0;
        RszPxlData = '0; OutPxlRdy = 1'b0;
        #12;
        checks++; if (RszPxlRdy !== 1'b1) begin failures++; $display("FAIL rst_rdy got=%b exp=1", RszPxlRdy); end
        checks++; if (OutPxlVld !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b exp=0", OutPxlVld); end
        checks++; if (OutPxlFirst !== 1'b1 || OutPxlLast !== 1'b0) begin failures++; $display("FAIL rst_first_last got=%b%b exp=10", OutPxlFirst, OutPxlLast); end
        checks++; if (TileCnt !== 16'd0) begin failures++; $display("FAIL rst_tilecnt got=%0d exp=0", TileCnt); end
        checks++; if (ErrOor !== 1'b0) begin failures++; $display("FAIL rst_erroor got=%b exp=0", ErrOor); end
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_raster();
        pix_t e;
        OutPxlRdy = 1'b1;
        for (int i = 0; i <= W * H; i++) begin
            if (i < W * H) begin
                e = mk(1, i % W, i / W);
                RszPxlVld = 1'b1; RszPxlX = e.x; RszPxlY = e.y; RszPxlData = e.d;
            end else begin
                RszPxlVld = 1'b0;
            end
            @(negedge clk);
            if (i < W * H) begin
                checks++; if (RszPxlRdy !== 1'b1) begin failures++; $display("FAIL raster_rdy%0d got=%b exp=1", i, RszPxlRdy); end
            end
            if (i == 0) begin
                checks++; if (OutPxlVld !== 1'b0) begin failures++; $display("FAIL raster_vld0 got=%b exp=0", OutPxlVld); end
            end else begin
                e = mk(1, (i - 1) % W, (i - 1) / W);
                checks++; if (OutPxlVld !== 1'b1 || observed() !== e) begin failures++; $display("FAIL raster_out%0d got=%b/%h exp=1/%h", i - 1, OutPxlVld, observed(), e); end
            end
            @(posedge clk); #1;
        end
        OutPxlRdy = 1'b0;
        @(negedge clk);
        checks++; if (TileCnt !== 16'd1 || OutPxlVld !== 1'b0) begin failures++; $display("FAIL raster_done got=%0d/%b exp=1/0", TileCnt, OutPxlVld); end
        @(posedge clk); #1;
    endtask

    task automatic test_reverse();
        pix_t e;
        OutPxlRdy = 1'b1;
        for (int k = W * H - 1; k >= 0; k--) begin
            e = mk(2, k % W, k / W);
            RszPxlVld = 1'b1; RszPxlX = e.x; RszPxlY = e.y; RszPxlData = e.d;
            @(negedge clk);
            checks++; if (OutPxlVld !== 1'b0) begin failures++; $display("FAIL reverse_hold%0d got=%b exp=0", k, OutPxlVld); end
            @(posedge clk); #1;
        end
        RszPxlVld = 1'b0;
        for (int i = 0; i < W * H; i++) begin
            e = mk(2, i % W, i / W);
            @(negedge clk);
            checks++; if (OutPxlVld !== 1'b1 || observed() !== e) begin failures++; $display("FAIL reverse_out%0d got=%b/%h exp=1/%h", i, OutPxlVld, observed(), e); end
            @(posedge clk); #1;
        end
        OutPxlRdy = 1'b0;
        @(negedge clk);
        checks++; if (TileCnt !== 16'd2) begin failures++; $display("FAIL reverse_tilecnt got=%0d exp=2", TileCnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_duplicate();
        pix_t a, b, c, e;
        pix_t sq[$];
        pix_t ex[$];
        pix_t got[$];
        bit   s_ok, r_ok, st_ok;
        a = mk(3, 0, 0); b = mk(3, 1, 0); c = mk(5, 1, 0);
        OutPxlRdy = 1'b0;
        RszPxlVld = 1'b1; RszPxlX = a.x; RszPxlY = a.y; RszPxlData = a.d;
        @(posedge clk); #1;
        RszPxlX = b.x; RszPxlY = b.y; RszPxlData = b.d;
        @(posedge clk); #1;
        RszPxlX = c.x; RszPxlY = c.y; RszPxlData = c.d;
        @(negedge clk);
        checks++; if (RszPxlRdy !== 1'b0) begin failures++; $display("FAIL dup_stall_a got=%b exp=0", RszPxlRdy); end
        checks++; if (OutPxlVld !== 1'b1 || OutPxlData !== a.d) begin failures++; $display("FAIL dup_head got=%b/%h exp=1/%h", OutPxlVld, OutPxlData, a.d); end
        @(posedge clk); #1;
        OutPxlRdy = 1'b1;
        @(negedge clk);
        checks++; if (RszPxlRdy !== 1'b0) begin failures++; $display("FAIL dup_stall_b got=%b exp=0", RszPxlRdy); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (RszPxlRdy !== 1'b0 || observed() !== b) begin failures++; $display("FAIL dup_drain got=%b/%h exp=0/%h", RszPxlRdy, observed(), b); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (RszPxlRdy !== 1'b1 || OutPxlVld !== 1'b0) begin failures++; $display("FAIL dup_accept got=%b/%b exp=1/0", RszPxlRdy, OutPxlVld); end
        @(posedge clk); #1;
        RszPxlVld = 1'b0; OutPxlRdy = 1'b0;
        for (int i = 2; i < W * H; i++) begin
            e = mk(3, i % W, i / W);
            sq.push_back(e); ex.push_back(e);
        end
        for (int i = 0; i < W * H; i++) begin
            if (i == 1) begin
                ex.push_back(c);
            end else begin
                e = mk(5, i % W, i / W);
                sq.push_back(e); ex.push_back(e);
            end
        end
        stream(sq, ex.size(), 100, got, s_ok, r_ok, st_ok);
        checks++; if (!s_ok || !r_ok) begin failures++; $display("FAIL dup_stream got=%b%b exp=11", s_ok, r_ok); end
        foreach (ex[i]) begin
            checks++; if (i >= got.size() || got[i] !== ex[i]) begin failures++; $display("FAIL dup_beat%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : pix_t'('0), ex[i]); end
        end
        @(negedge clk);
        checks++; if (TileCnt !== 16'd4) begin failures++; $display("FAIL dup_tilecnt got=%0d exp=4", TileCnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        pix_t sq[$];
        pix_t got[$];
        bit   s_ok, r_ok, st_ok;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < W * H; i++) sq.push_back(mk(10 + t, i % W, i / W));
        end
        stream(sq, sq.size(), 50, got, s_ok, r_ok, st_ok);
        checks++; if (!s_ok || !r_ok) begin failures++; $display("FAIL b2b_stream got=%b%b exp=11", s_ok, r_ok); end
        checks++; if (!st_ok) begin failures++; $display("FAIL b2b_stable got=%b exp=1", st_ok); end
        foreach (sq[i]) begin
            checks++; if (i >= got.size() || got[i] !== sq[i]) begin failures++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : pix_t'('0), sq[i]); end
        end
        @(negedge clk);
        checks++; if (TileCnt !== 16'd7) begin failures++; $display("FAIL b2b_tilecnt got=%0d exp=7", TileCnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        pix_t e;
        pix_t sq[$];
        pix_t got[$];
        bit   s_ok, r_ok, st_ok;
        OutPxlRdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = mk(7, i % W, i / W);
            RszPxlVld = 1'b1; RszPxlX = e.x; RszPxlY = e.y; RszPxlData = e.d;
            @(posedge clk); #1;
        end
        RszPxlVld = 1'b0; OutPxlRdy = 1'b0; RszPxlX = '0; RszPxlY = YW'(1);
        #2;
        checks++; if (OutPxlVld !== 1'b1 || OutPxlX !== XW'(0) || OutPxlY !== YW'(1)) begin failures++; $display("FAIL mrst_pre got=%b/%0d/%0d exp=1/0/1", OutPxlVld, OutPxlX, OutPxlY); end
        rst_n = 1'b0;
        #1;
        checks++; if (OutPxlVld !== 1'b0 || OutPxlY !== YW'(0) || OutPxlFirst !== 1'b1) begin failures++; $display("FAIL mrst_ptr got=%b/%0d/%b exp=0/0/1", OutPxlVld, OutPxlY, OutPxlFirst); end
        checks++; if (RszPxlRdy !== 1'b1 || TileCnt !== 16'd0) begin failures++; $display("FAIL mrst_state got=%b/%0d exp=1/0", RszPxlRdy, TileCnt); end
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < W * H; i++) sq.push_back(mk(8, i % W, i / W));
        stream(sq, sq.size(), 100, got, s_ok, r_ok, st_ok);
        checks++; if (!s_ok || !r_ok) begin failures++; $display("FAIL mrst_stream got=%b%b exp=11", s_ok, r_ok); end
        foreach (sq[i]) begin
            checks++; if (i >= got.size() || got[i] !== sq[i]) begin failures++; $display("FAIL mrst_beat%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : pix_t'('0), sq[i]); end
        end
        @(negedge clk);
        checks++; if (TileCnt !== 16'd1) begin failures++; $display("FAIL mrst_tilecnt got=%0d exp=1", TileCnt); end
        @(posedge clk); #1;
    endtask

`ifdef IMG_RSZ_COLLECTOR_OOR_CHK_EN
    task automatic test_oor();
        pix_t sq[$];
        pix_t got[$];
        bit   s_ok, r_ok, st_ok;
        RszPxlVld = 1'b1; RszPxlX = XW'(5); RszPxlY = '0; RszPxlData = pd(9, 5, 0);
        @(negedge clk);
        checks++; if (RszPxlRdy !== 1'b1) begin failures++; $display("FAIL oor_rdy got=%b exp=1", RszPxlRdy); end
        @(posedge clk); #1;
        RszPxlVld = 1'b0;
        @(negedge clk);
        checks++; if (ErrOor !== 1'b1 || OutPxlVld !== 1'b0) begin failures++; $display("FAIL oor_flag got=%b/%b exp=1/0", ErrOor, OutPxlVld); end
        @(posedge clk); #1;
        for (int i = 0; i < W * H; i++) sq.push_back(mk(9, i % W, i / W));
        stream(sq, sq.size(), 100, got, s_ok, r_ok, st_ok);
        checks++; if (!s_ok || !r_ok) begin failures++; $display("FAIL oor_stream got=%b%b exp=11", s_ok, r_ok); end
        foreach (sq[i]) begin
            checks++; if (i >= got.size() || got[i] !== sq[i]) begin failures++; $display("FAIL oor_beat%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : pix_t'('0), sq[i]); end
        end
        @(negedge clk);
        checks++; if (ErrOor !== 1'b1 || TileCnt !== 16'd2) begin failures++; $display("FAIL oor_after got=%b/%0d exp=1/2", ErrOor, TileCnt); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_raster();
        test_reverse();
        test_duplicate();
        test_back_to_back();
        test_mid_reset();
`ifdef IMG_RSZ_COLLECTOR_OOR_CHK_EN
        test_oor();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

`default_nettype wire
